// File: rtl/vproc_pkg.sv
// vproc_pkg: shared types and constants for the vector datapath.
//   LANES/LANE_W/VEC_W : vector geometry (4 x 32 = 128 bits)
//   REG_AW/MEM_AW      : register-bank and memory address widths
//   lane_t/vec_t       : lane and full-vector data types
//   ld_state_e         : vector load FSM states
package vproc_pkg;

  localparam int LANES   = 4;
  localparam int LANE_W  = 32;
  localparam int VEC_W   = LANES * LANE_W;
  localparam int REG_AW  = 4;
  localparam int MEM_AW  = 32;
  localparam int LANE_IW = $clog2(LANES);

  typedef logic [LANE_W-1:0]  lane_t;
  typedef logic [VEC_W-1:0]   vec_t;
  typedef logic [LANE_IW-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/vlane_packer.sv
// vlane_packer: 128-bit vector assembly register.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : clear the whole register (priority over writes)
//   wr_en       : write wr_data into the register this edge
//   wr_lane     : target lane for a normal write (lane 0 at LSBs)
//   bcast_fill  : when writing, replicate wr_data into every lane
//   wr_data     : lane data
//   vec         : current assembled vector
module vlane_packer
  import vproc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      wr_en,
  input  lane_idx_t wr_lane,
  input  logic      bcast_fill,
  input  lane_t     wr_data,
  output vec_t      vec
);

  vec_t vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (clr) begin
      vec_d = '0;
    end else if (wr_en) begin
      if (bcast_fill) begin
        vec_d = {LANES{wr_data}};
      end else begin
        vec_d[wr_lane*LANE_W +: LANE_W] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vec_q <= '0;
    else     vec_q <= vec_d;
  end

  assign vec = vec_q;

endmodule

// File: rtl/vreg_loader.sv
// vreg_loader: vector load writer for the vector register bank.
// Reads four consecutive 32-bit words starting at base_addr (one per cycle,
// one-cycle memory latency), packs them into a 128-bit vector and writes it
// to the bank through we3/wa3/wd3 for one cycle.
// Optional feature: define VLOADER_BCAST_EN to add the bcast input; a command
// with bcast=1 reads one word and replicates it into all lanes.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, dst, base_addr [, bcast] : command (sampled only in IDLE)
//   busy, done          : status; done pulses with we3
//   mem_re, mem_addr    : memory read request / byte address
//   mem_rdata           : read data, valid the cycle after mem_re
//   we3, wa3, wd3       : register bank write port
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, busy=0
// S_REQ   | issuing reads, lane counter 0..3 (0 only for bcast)
// S_DRAIN | last read data arrives and is captured
// S_WRITE | we3/done high for one cycle, then back to S_IDLE
module vreg_loader
  import vproc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] dst,
  input  logic [MEM_AW-1:0] base_addr,
`ifdef VLOADER_BCAST_EN
  input  logic              bcast,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [VEC_W-1:0]  wd3
);

  ld_state_e         state_q, state_d;
  lane_idx_t         cnt_q, cnt_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic              cap_v_q, cap_v_d;
  lane_idx_t         cap_lane_q, cap_lane_d;
  logic              bcast_q, bcast_d;
  logic              accept;
  vec_t              vec;

  assign accept = (state_q == S_IDLE) && start;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dst_q      <= '0;
      base_q     <= '0;
      cap_v_q    <= 1'b0;
      cap_lane_q <= '0;
      bcast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dst_q      <= dst_d;
      base_q     <= base_d;
      cap_v_q    <= cap_v_d;
      cap_lane_q <= cap_lane_d;
      bcast_q    <= bcast_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dst_d      = dst_q;
    base_d     = base_q;
    bcast_d    = bcast_q;
    // Each read's data is captured one cycle after its request.
    cap_v_d    = (state_q == S_REQ);
    cap_lane_d = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          cnt_d   = '0;
          dst_d   = dst;
          base_d  = base_addr;
`ifdef VLOADER_BCAST_EN
          bcast_d = bcast;
`else
          bcast_d = 1'b0;
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bcast_q || (cnt_q == lane_idx_t'(LANES-1))) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    mem_re   = (state_q == S_REQ);
    we3      = (state_q == S_WRITE);
    done     = we3;
    // Address wraps modulo 2^MEM_AW; base low bits pass through untouched.
    mem_addr = mem_re ? (base_q + {{(MEM_AW-LANE_IW-2){1'b0}}, cnt_q, 2'b00}) : '0;
    wa3      = we3 ? dst_q : '0;
    wd3      = we3 ? vec   : '0;
  end

  vlane_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .wr_en      (cap_v_q),
    .wr_lane    (cap_lane_q),
    .bcast_fill (bcast_q),
    .wr_data    (mem_rdata),
    .vec        (vec)
  );

endmodule

// File: tb/tb_vreg_loader.sv
// Directed testbench for vreg_loader with a one-cycle-latency memory model.
module tb_vreg_loader;
  import vproc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [REG_AW-1:0] dst;
  logic [MEM_AW-1:0] base_addr;
  logic              bcast;
  logic              busy, done, mem_re, we3;
  logic [MEM_AW-1:0] mem_addr;
  logic [LANE_W-1:0] mem_rdata = '0;
  logic [REG_AW-1:0] wa3;
  logic [VEC_W-1:0]  wd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vreg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dst       (dst),
    .base_addr (base_addr),
`ifdef VLOADER_BCAST_EN
    .bcast     (bcast),
`endif
    .busy      (busy),
    .done      (done),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h100: memf = 32'h11;
      32'h104: memf = 32'h22;
      32'h108: memf = 32'h33;
      32'h10C: memf = 32'h44;
      32'h040: memf = 32'hDEADBEEF;
      default: memf = a ^ 32'hC0DE0000;
    endcase
  endfunction

  always @(posedge clk) if (mem_re) mem_rdata <= memf(mem_addr);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_re"},   128'(mem_re), 128'd0);
    check({tag, "_addr"}, 128'(mem_addr), 128'd0);
    check({tag, "_we3"},  128'(we3), 128'd0);
    check({tag, "_wa3"},  128'(wa3), 128'd0);
    check({tag, "_wd3"},  wd3, 128'd0);
  endtask

  // Full four-read command starting from IDLE; optionally pulses start in
  // the WRITE cycle to show it is ignored.
  task automatic run_cmd(input logic [3:0] d, input logic [31:0] b,
                         input logic [127:0] exp_wd, input bit start_in_write);
    logic [31:0] ea;
    dst = d; base_addr = b; start = 1'b1;
    tick();
    start = 1'b0; dst = ~d; base_addr = 32'h5000;
    for (int c = 0; c < 4; c++) begin
      ea = b + 32'(4 * c);
      check($sformatf("req%0d_re", c), 128'(mem_re), 128'd1);
      check($sformatf("req%0d_addr", c), 128'(mem_addr), 128'(ea));
      check($sformatf("req%0d_busy", c), 128'(busy), 128'd1);
      tick();
    end
    check("drain_re", 128'(mem_re), 128'd0);
    check("drain_addr", 128'(mem_addr), 128'd0);
    check("drain_we3", 128'(we3), 128'd0);
    check("drain_busy", 128'(busy), 128'd1);
    if (start_in_write) start = 1'b1;
    tick();
    check("wr_we3", 128'(we3), 128'd1);
    check("wr_done", 128'(done), 128'd1);
    check("wr_wa3", 128'(wa3), 128'(d));
    check("wr_wd3", wd3, exp_wd);
    check("wr_busy", 128'(busy), 128'd1);
    tick();
    start = 1'b0;
    check_quiet("post");
  endtask

  initial begin
    int we_seen;
    bit exp_re;
    rst = 1'b1; start = 1'b0; dst = '0; base_addr = '0; bcast = 1'b0;
    tick(); tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Basic command
    run_cmd(4'd3, 32'h100, 128'h00000044_00000033_00000022_00000011, 1'b0);

    // Address wrap past 0xFFFFFFFC, start asserted during WRITE
    run_cmd(4'd12, 32'hFFFFFFF8,
            128'hC0DE0004_C0DE0000_3F21FFFC_3F21FFF8, 1'b1);

    // start held high: second command accepted only at E7
    dst = 4'd5; base_addr = 32'h200; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 12) start = 1'b0;
      exp_re = ((c >= 1 && c <= 4) || (c >= 8 && c <= 11));
      check($sformatf("hold_c%0d_re", c), 128'(mem_re), 128'(exp_re));
      if (c == 6 || c == 13) check($sformatf("hold_c%0d_we3", c), 128'(we3), 128'd1);
      if (c == 7) check("hold_c7_busy", 128'(busy), 128'd0);
      if (c == 13) check("hold_wd3", wd3, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);
    end
    tick();
    check_quiet("hold_end");

    // Reset pulsed in cycle 4
    dst = 4'd7; base_addr = 32'h300; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rst_c4_addr", 128'(mem_addr), 128'h30C);
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    tick();
    rst = 1'b0;
    we_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (we3 || busy) we_seen++;
    end
    check("rst_no_write", 128'(we_seen), 128'd0);
    run_cmd(4'd2, 32'h100, 128'h00000044_00000033_00000022_00000011, 1'b0);

`ifdef VLOADER_BCAST_EN
    dst = 4'd1; base_addr = 32'h40; bcast = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; bcast = 1'b0;
    check("bc_c1_re", 128'(mem_re), 128'd1);
    check("bc_c1_addr", 128'(mem_addr), 128'h40);
    tick();
    check("bc_c2_re", 128'(mem_re), 128'd0);
    check("bc_c2_busy", 128'(busy), 128'd1);
    check("bc_c2_we3", 128'(we3), 128'd0);
    tick();
    check("bc_c3_we3", 128'(we3), 128'd1);
    check("bc_c3_wa3", 128'(wa3), 128'd1);
    check("bc_c3_wd3", wd3, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    tick();
    check_quiet("bc_end");
    run_cmd(4'd4, 32'h100, 128'h00000044_00000033_00000022_00000011, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
